// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with occupancy count and threshold flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise they read 0.
module sync_fifo_fwft #(
  parameter  int DATA_WIDTH          = 8,
  parameter  int ADDRESS_WIDTH       = 4,
  localparam int FIFO_DEPTH          = (1 << ADDRESS_WIDTH),
  parameter  int ALMOST_FULL_THRESH  = FIFO_DEPTH - 2,
  parameter  int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     almost_full,
  output logic [DATA_WIDTH-1:0]    dout,
  input  logic                     rd_en,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [ADDRESS_WIDTH:0]   data_count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int CW = ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0]            DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]            AF_C    = CW'(ALMOST_FULL_THRESH);
  localparam logic [CW-1:0]            AE_C    = CW'(ALMOST_EMPTY_THRESH);
  localparam logic [CW-1:0]            CNT_ONE = CW'(1);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = ADDRESS_WIDTH'(1);

  logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]            count_q, count_d;
  logic                     full_q, empty_q, almost_full_q, almost_empty_q;
  logic                     wr_acc, rd_acc;

  always_comb begin
    wr_acc  = wr_en & ~full_q;
    rd_acc  = rd_en & ~empty_q;
    count_d = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CNT_ONE;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Storage carries no reset; a write coinciding with reset is suppressed.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Flags derive from count_d so they move on the same edge as the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q        <= count_d;
      full_q         <= (count_d == DEPTH_C);
      empty_q        <= (count_d == '0);
      almost_full_q  <= (count_d >= AF_C);
      almost_empty_q <= (count_d <= AE_C);
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && full_q)  overflow_q  <= 1'b1;
      if (rd_en && empty_q) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign dout         = mem_q[rd_ptr_q];
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign data_count   = count_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Scoreboard bench for sync_fifo_fwft at default parameters (depth 16).
// A queue model tracks expected contents; status is compared after every edge.
module tb_sync_fifo_fwft;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       full, almost_full, empty, almost_empty, overflow, underflow;
  logic [7:0] dout;
  logic [4:0] data_count;

  sync_fifo_fwft dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .wr_en        (wr_en),
    .full         (full),
    .almost_full  (almost_full),
    .dout         (dout),
    .rd_en        (rd_en),
    .empty        (empty),
    .almost_empty (almost_empty),
    .data_count   (data_count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  logic [7:0] mq [$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_status();
    int n;
    n = mq.size();
    check("count",        32'(data_count),   32'(n));
    check("empty",        32'(empty),        32'(n == 0));
    check("full",         32'(full),         32'(n == DEPTH));
    check("almost_full",  32'(almost_full),  32'(n >= DEPTH - 2));
    check("almost_empty", 32'(almost_empty), 32'(n <= 2));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("underflow",    32'(underflow),    32'(m_unf));
`else
    check("overflow",     32'(overflow),     32'(0));
    check("underflow",    32'(underflow),    32'(0));
`endif
    if (n > 0) check("head", 32'(dout), 32'(mq[0]));
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r);
    logic wa, ra;
    @(negedge clk);
    wr_en = w;
    din   = d;
    rd_en = r;
    wa = w && (mq.size() < DEPTH);
    ra = r && (mq.size() > 0);
    if (w && mq.size() == DEPTH) m_ovf = 1'b1;
    if (r && mq.size() == 0)     m_unf = 1'b1;
    if (ra) check("dout", 32'(dout), 32'(mq[0]));
    @(posedge clk);
    #1;
    if (ra) void'(mq.pop_front());
    if (wa) mq.push_back(d);
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_status();
  endtask

  task automatic do_reset(input logic w, input logic [7:0] d);
    @(negedge clk);
    rst   = 1'b1;
    wr_en = w;
    din   = d;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_status();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_status();

    // fill with 0x01..0x10, then one dropped write
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'h55, 1'b0);

    // drain in order, then one read past empty
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // single-word latency
    do_reset(1'b0, 8'h00);
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b1);

    // steady state at 8 across pointer wraps
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h28 + i), 1'b1);

    // full with both requests: read wins, 0x77 dropped
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b1, 8'h77, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 1'b1);

    // empty with both requests: write wins
    step(1'b1, 8'h3C, 1'b1);

    // reset mid-stream at count 5 with a write in flight
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    check("pre_reset_count", 32'(data_count), 32'(5));
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h61, 1'b0);
    do_reset(1'b1, 8'hEE);
    step(1'b1, 8'h99, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
- Single-clock, parametrised FIFO with first-word-fall-through (FWFT) read, occupancy count, programmable almost-full/almost-empty thresholds and optional sticky error flags.
- Next-generation buffer for same-clock-domain paths in the adapter datapath, e.g. TLP header/payload staging.
- Replaces ad-hoc use of the dual-clock FIFO where both ports share one clock.

Parameters:
- DATA_WIDTH, 8: width of din/dout in bits.
- ADDRESS_WIDTH, 4: pointer width; must be >= 2.
- FIFO_DEPTH, (1 << ADDRESS_WIDTH): number of entries; power of two only, not to be overridden independently.
- ALMOST_FULL_THRESH, FIFO_DEPTH-2: almost_full asserted when count >= this value; legal range 1..FIFO_DEPTH.
- ALMOST_EMPTY_THRESH, 2: almost_empty asserted when count <= this value; legal range 0..FIFO_DEPTH-1.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  DATA_WIDTH  write data.
- wr_en  input  1  write request.
- full  output  1  registered; no write accepted while high.
- almost_full  output  1  registered threshold flag.
- dout  output  DATA_WIDTH  FWFT head-of-queue data; valid whenever empty==0.
- rd_en  input  1  pop request; consumes the word currently on dout.
- empty  output  1  registered; no read accepted while high.
- almost_empty  output  1  registered threshold flag.
- data_count  output  ADDRESS_WIDTH+1  registered occupancy, 0..FIFO_DEPTH.
- overflow  output  1  sticky error flag (see Optional Feature).
- underflow  output  1  sticky error flag (see Optional Feature).

Behaviour:
- Storage: FIFO_DEPTH x DATA_WIDTH array, binary write and read pointers of ADDRESS_WIDTH bits. Pointers wrap modulo FIFO_DEPTH with no special case.
- Accept rules:
  - wr_acc = wr_en & ~full
  - rd_acc = rd_en & ~empty
  - Both evaluated on the flag values present at the start of the cycle.
- Write: on wr_acc, mem[wr_ptr] <= din and wr_ptr++.
- Read: dout is driven combinationally from mem[rd_ptr]. On rd_acc, rd_ptr++ and the next word appears on dout in the following cycle.
  - dout content while empty==1 is don't-care.
- Count: data_count_next = data_count + wr_acc - rd_acc.
  - Simultaneous wr_acc and rd_acc leaves the count unchanged.
- Flags, all registered and computed from data_count_next so they update on the same edge as the count:
  - full = (next==FIFO_DEPTH)
  - empty = (next==0)
  - almost_full = (next >= ALMOST_FULL_THRESH)
  - almost_empty = (next <= ALMOST_EMPTY_THRESH)
- Latency: a word written at edge N is visible on dout and empty=0 after edge N, i.e. 1 cycle write-to-read.
- Boundary conditions:
  - Full with wr_en & rd_en: read accepted, write dropped; full deasserts next cycle.
  - Empty with wr_en & rd_en: write accepted, read ignored; empty deasserts next cycle.
  - Not full and not empty with both: both accepted; count and flags unchanged; the data path stays correct across the pointer wrap.
- Reset (rst=1 at an edge):
  - wr_ptr=rd_ptr=0, data_count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
  - Any in-flight wr_en/rd_en in the reset cycle is ignored.
  - Memory contents are not cleared.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow is set on any edge with wr_en & full.
  - underflow is set on any edge with rd_en & empty.
  - Both flags are sticky until rst and appear the cycle after the offending request.
- Undefined: overflow and underflow are tied to 0 and no flag registers are built. The port list is identical in both builds.

Test Plan:
- Reset then write 0x01..0x10 (DEPTH 16), no reads -> full=1 after the 16th write edge, data_count=16, almost_full=1 from count 14. A 17th write with 0x55 is dropped; overflow=1 when the macro is defined, otherwise 0.
- From full, read 16 times -> dout sequence 0x01..0x10 in order, empty=1 after the last read, almost_empty=1 from count 2. An extra rd_en gives underflow=1 when the macro is defined.
- Single write 0xA5 into an empty FIFO -> empty=0 and dout=0xA5 the cycle after the write edge; rd_en that cycle -> empty=1 the next cycle.
- Fill to 8, then 40 cycles of simultaneous wr_en/rd_en with an incrementing pattern -> data_count stays at 8, output order preserved across two pointer wraps.
- Full plus simultaneous wr_en/rd_en with din=0x77 -> count=15, full=0, 0x77 not stored. Empty plus both -> count=1, dout=din.
- Assert rst mid-stream at count=5 with wr_en=1 -> next cycle count=0, empty=1, sticky flags cleared, and the following write/read returns only new data.
